// File: rtl/fir_pkg.sv
// Shared constants for the FIR control plane.
// AXI response codes, register map indices and a width helper.
package fir_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int CTRL      = 0;
    localparam int STATUS    = 1;
    localparam int TAP_COUNT = 2;
    localparam int COEFF     = 3;

    // Never returns less than 1 so that index fields stay non-empty.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/fir_axi_wchan.sv
// AXI4-Lite write address/data capture.
// AW and W are buffered independently; commit fires once both are held.
module fir_axi_wchan
    import fir_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            init,
    input  logic [AW-1:0]   awaddr,
    input  logic            awvalid,
    output logic            awready,
    input  logic [DW-1:0]   wdata,
    input  logic [DW/8-1:0] wstrb,
    input  logic            wvalid,
    output logic            wready,
    input  logic            bvalid,
    input  logic            bready,
    output logic [AW-1:0]   addr,
    output logic [DW-1:0]   data,
    output logic [DW/8-1:0] strb,
    output logic            commit
);

    logic aw_full;
    logic w_full;

    assign awready = ~aw_full & ~init;
    assign wready  = ~w_full & ~init;
    assign commit  = aw_full & w_full & (~bvalid | bready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            addr    <= '0;
            data    <= '0;
            strb    <= '0;
        end else begin
            if (commit) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
            end
            if (awvalid && awready) begin
                aw_full <= 1'b1;
                addr    <= awaddr;
            end
            if (wvalid && wready) begin
                w_full <= 1'b1;
                data   <= wdata;
                strb   <= wstrb;
            end
        end
    end

endmodule

// File: rtl/fir_axi_regbank.sv
// FIR control-plane AXI4-Lite register bank.
// Parametrised count with RW, read-only status and self-clearing slots.
module fir_axi_regbank
    import fir_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int NUM_REGS = 8,
    parameter logic [63:0] RO_MASK = 64'h02,
    parameter logic [63:0] SC_MASK = 64'h01,
    parameter logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                                   S_AXI_ACLK,
    input  logic                                   S_AXI_ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                             S_AXI_AWPROT,
    input  logic                                   S_AXI_AWVALID,
    output logic                                   S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                                   S_AXI_WVALID,
    output logic                                   S_AXI_WREADY,
    output logic [1:0]                             S_AXI_BRESP,
    output logic                                   S_AXI_BVALID,
    input  logic                                   S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                             S_AXI_ARPROT,
    input  logic                                   S_AXI_ARVALID,
    output logic                                   S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                             S_AXI_RRESP,
    output logic                                   S_AXI_RVALID,
    input  logic                                   S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_in,
    output logic [NUM_REGS-1:0]                    wr_pulse,
    output logic [NUM_REGS-1:0]                    rd_pulse
);

    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int AW       = C_S_AXI_ADDR_WIDTH;
    localparam int NB       = DW / 8;
    localparam int ADDR_LSB = clog2(NB);
    localparam int IDX_W    = clog2(NUM_REGS);

    logic                init;
    logic [DW-1:0]       regs  [NUM_REGS];
    logic [DW-1:0]       ro_sh [NUM_REGS];
    logic [NUM_REGS-1:0] sc_pend;
    logic [NUM_REGS-1:0] wsel;
    logic [NUM_REGS-1:0] rsel;
    logic [AW-1:0]       waddr;
    logic [DW-1:0]       wdata;
    logic [NB-1:0]       wstrb;
    logic                commit;
    logic                wok;
    logic                rmap;
    logic                ar_hs;
    logic [IDX_W-1:0]    widx;
    logic [IDX_W-1:0]    ridx;
    logic [DW-1:0]       rd_val;
    logic                unused_ok;

    function automatic logic is_mapped(input logic [AW-1:0] a);
        logic ok;
        ok = int'(a[ADDR_LSB +: IDX_W]) < NUM_REGS;
        for (int b = ADDR_LSB + IDX_W; b < AW; b++)
            if (a[b]) ok = 1'b0;
        return ok;
    endfunction

    fir_axi_wchan #(
        .AW(AW),
        .DW(DW)
    ) u_wchan (
        .clk     (S_AXI_ACLK),
        .rst     (S_AXI_ARESET),
        .init    (init),
        .awaddr  (S_AXI_AWADDR),
        .awvalid (S_AXI_AWVALID),
        .awready (S_AXI_AWREADY),
        .wdata   (S_AXI_WDATA),
        .wstrb   (S_AXI_WSTRB),
        .wvalid  (S_AXI_WVALID),
        .wready  (S_AXI_WREADY),
        .bvalid  (S_AXI_BVALID),
        .bready  (S_AXI_BREADY),
        .addr    (waddr),
        .data    (wdata),
        .strb    (wstrb),
        .commit  (commit)
    );

    assign widx          = waddr[ADDR_LSB +: IDX_W];
    assign ridx          = S_AXI_ARADDR[ADDR_LSB +: IDX_W];
    assign wok           = is_mapped(waddr) & ~RO_MASK[widx];
    assign rmap          = is_mapped(S_AXI_ARADDR);
    assign S_AXI_ARREADY = ~S_AXI_RVALID & ~init;
    assign ar_hs         = S_AXI_ARVALID & S_AXI_ARREADY;
    assign unused_ok     = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                             waddr[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

    always_comb begin
        wsel   = '0;
        rsel   = '0;
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (commit && wok && int'(widx) == i) wsel[i] = 1'b1;
            if (ar_hs && rmap && int'(ridx) == i) rsel[i] = 1'b1;
            if (int'(ridx) == i) rd_val = RO_MASK[i] ? ro_sh[i] : regs[i];
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_out
        assign reg_out[g*DW +: DW] = regs[g];
    end

    // Holds readies low for one edge after reset release.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) init <= 1'b1;
        else              init <= 1'b0;
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i]  <= RESET_VAL[i*DW +: DW];
                ro_sh[i] <= '0;
            end
            sc_pend  <= '0;
            wr_pulse <= '0;
            rd_pulse <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                ro_sh[i] <= RO_MASK[i] ? reg_in[i*DW +: DW] : '0;
                if (sc_pend[i]) regs[i] <= RESET_VAL[i*DW +: DW];
                if (wsel[i])
                    for (int b = 0; b < NB; b++)
                        if (wstrb[b]) regs[i][b*8 +: 8] <= wdata[b*8 +: 8];
            end
            sc_pend  <= wsel & SC_MASK[NUM_REGS-1:0];
            wr_pulse <= wsel;
            rd_pulse <= rsel;
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= RESP_OKAY;
        end else if (commit) begin
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP  <= wok ? RESP_OKAY : RESP_SLVERR;
        end else if (S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            S_AXI_RVALID <= 1'b0;
            S_AXI_RRESP  <= RESP_OKAY;
            S_AXI_RDATA  <= '0;
        end else if (ar_hs) begin
            S_AXI_RVALID <= 1'b1;
            S_AXI_RRESP  <= rmap ? RESP_OKAY : RESP_SLVERR;
            S_AXI_RDATA  <= rmap ? rd_val : '0;
        end else if (S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fir_axi_regbank.sv
// Randomised self-checking bench for fir_axi_regbank.
// A word-level register model predicts every response and register value.
module tb_fir_axi_regbank;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int N  = 8;
    localparam logic [N*DW-1:0] RV = {32'h0, 32'h0, 32'h0, 32'hCAFE0004,
                                      32'h0, 32'h11223344, 32'h0, 32'h0};

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [AW-1:0]   awaddr = '0;
    logic [2:0]      awprot = '0;
    logic            awvalid = 1'b0;
    logic            awready;
    logic [DW-1:0]   wdata = '0;
    logic [3:0]      wstrb = '0;
    logic            wvalid = 1'b0;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready = 1'b0;
    logic [AW-1:0]   araddr = '0;
    logic [2:0]      arprot = '0;
    logic            arvalid = 1'b0;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready = 1'b0;
    logic [N*DW-1:0] reg_out;
    logic [N*DW-1:0] reg_in = '0;
    logic [N-1:0]    wr_pulse;
    logic [N-1:0]    rd_pulse;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [N];
    logic [31:0] status_val = '0;

    always #5 clk = ~clk;

    fir_axi_regbank #(
        .C_S_AXI_DATA_WIDTH(DW),
        .C_S_AXI_ADDR_WIDTH(AW),
        .NUM_REGS(N),
        .RO_MASK(64'h02),
        .SC_MASK(64'h01),
        .RESET_VAL(RV)
    ) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESET  (rst),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .reg_out       (reg_out),
        .reg_in        (reg_in),
        .wr_pulse      (wr_pulse),
        .rd_pulse      (rd_pulse)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rv_of(input int i);
        logic [N*DW-1:0] v;
        v = RV;
        return v[i*32 +: 32];
    endfunction

    function automatic logic [31:0] out_of(input int i);
        return reg_out[i*32 +: 32];
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < N; i++) model[i] = rv_of(i);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues AW/W (W leads AW by 'lead' cycles) and returns once BVALID is seen.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input int lead,
                             output logic [1:0] resp, output int lat,
                             output logic [N-1:0] wp);
        int  n;
        bit  awd, wd, awh, wh;
        awaddr = a;
        wdata  = d;
        wstrb  = s;
        wvalid = 1'b1;
        awvalid = (lead == 0);
        n = 0; awd = 0; wd = 0;
        while (!(awd && wd) && n < 50) begin
            awh = awvalid && awready;
            wh  = wvalid && wready;
            tick();
            n++;
            if (awh) begin awvalid = 1'b0; awd = 1; end
            if (wh)  begin wvalid  = 1'b0; wd  = 1; end
            if (n == lead && !awd) awvalid = 1'b1;
        end
        check("wr_handshake_timeout", {awd, wd}, 2'b11);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        lat = 0;
        while (!bvalid && lat < 20) begin
            tick();
            lat++;
        end
        resp = bresp;
        wp   = wr_pulse;
    endtask

    task automatic b_ack();
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] a, input bit ack,
                            output logic [31:0] d, output logic [1:0] resp,
                            output logic [N-1:0] rp);
        int n;
        bit hs;
        araddr  = a;
        arvalid = 1'b1;
        n = 0; hs = 0;
        while (!hs && n < 50) begin
            hs = arvalid && arready;
            tick();
            n++;
        end
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin
            tick();
            n++;
        end
        check("rd_timeout", rvalid, 1'b1);
        d    = rdata;
        resp = rresp;
        rp   = rd_pulse;
        if (ack) begin
            rready = 1'b1;
            tick();
            rready = 1'b0;
        end
    endtask

    function automatic bit mapped(input logic [31:0] a);
        return (a >> 2) < N;
    endfunction

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input int lead);
        logic [1:0]   resp;
        int           lat;
        logic [N-1:0] wp;
        int           idx;
        bit           ok;
        idx = int'(a >> 2);
        ok  = mapped(a) && idx != 1;
        axi_write(a, d, s, lead, resp, lat, wp);
        check("b_latency", lat, 1);
        check("bresp", resp, ok ? 2'b00 : 2'b10);
        check("wr_pulse", wp, ok ? (N'(1) << idx) : '0);
        if (ok)
            for (int b = 0; b < 4; b++)
                if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
        for (int i = 0; i < N; i++)
            if (out_of(i) !== model[i])
                check($sformatf("reg_out%0d_commit", i), out_of(i), model[i]);
        b_ack();
        check("wr_pulse_drop", wr_pulse, '0);
        check("bvalid_drop", bvalid, 1'b0);
        model[0] = rv_of(0);
        if (idx < N) check("reg_out_after", out_of(idx), model[idx]);
    endtask

    task automatic do_read(input logic [31:0] a);
        logic [31:0]  d;
        logic [1:0]   resp;
        logic [N-1:0] rp;
        int           idx;
        logic [31:0]  exp;
        idx = int'(a >> 2);
        exp = !mapped(a) ? 32'h0 : (idx == 1 ? status_val : model[idx]);
        axi_read(a, 1'b1, d, resp, rp);
        check("rdata", d, exp);
        check("rresp", resp, mapped(a) ? 2'b00 : 2'b10);
        check("rd_pulse", rp, mapped(a) ? (N'(1) << idx) : '0);
    endtask

    initial begin
        logic [1:0]   resp;
        int           lat;
        logic [N-1:0] wp;
        logic [31:0]  d;
        logic [31:0]  a;
        logic [31:0]  held;

        model_reset();
        repeat (3) tick();
        check("rst_bvalid", bvalid, 1'b0);
        check("rst_rvalid", rvalid, 1'b0);
        check("rst_awready", awready, 1'b0);
        check("rst_reg_out", reg_out, RV);
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("init_readies", {awready, wready, arready}, 3'b000);
        tick();
        check("post_init_readies", {awready, wready, arready}, 3'b111);
        for (int i = 0; i < N; i++) do_read(32'(i * 4));

        do_write(32'h0C, 32'hDEADBEEF, 4'hF, 3);
        do_write(32'h08, 32'hAABBCCDD, 4'b0101, 0);
        check("strb_merge", out_of(2), 32'h11BB33DD);

        status_val = $urandom;
        reg_in[32 +: 32] = status_val;
        tick();
        do_write(32'h04, 32'h12345678, 4'hF, 0);
        check("ro_unchanged", out_of(1), rv_of(1));
        do_read(32'h04);
        do_read(32'h24);

        axi_write(32'h0, 32'h1, 4'hF, 0, resp, lat, wp);
        check("sc_visible", out_of(0), 32'h1);
        tick();
        check("sc_cleared", out_of(0), rv_of(0));
        b_ack();

        for (int k = 0; k < 30; k++) begin
            a = 32'($urandom_range(0, 9) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) a = a | 32'h0001_0000;
            do_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
            a = 32'($urandom_range(0, 9) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) a = a | 32'h8000_0000;
            do_read(a);
        end

        axi_write(32'h14, 32'h55AA55AA, 4'hF, 0, resp, lat, wp);
        model[5] = 32'h55AA55AA;
        held = bresp;
        axi_read(32'h14, 1'b0, d, resp, wp);
        check("stall_rdata", d, model[5]);
        awaddr = 32'h14; wdata = 32'h01020304; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("stall_bvalid", {bvalid, bresp}, {1'b1, held[1:0]});
            check("stall_no_commit", out_of(5), model[5]);
            check("stall_no_pulse", wr_pulse, '0);
            tick();
        end
        #3 rst = 1'b1;
        #1;
        check("async_valids", {bvalid, rvalid}, 2'b00);
        model_reset();
        check("async_reg_out", out_of(5), model[5]);
        @(posedge clk);
        #3 rst = 1'b0;
        bready = 1'b1;
        rready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            check("no_stale_resp", {bvalid, rvalid, wr_pulse}, '0);
        end
        bready = 1'b0;
        rready = 1'b0;
        do_read(32'h14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule
